turn_sequencer: RTL
===================

# turn_sequencer

Turn controller for the enemy sprite units. It alternates a player phase with a round of enemy phases. In each enemy phase it starts one live enemy at a frame boundary, waits for that enemy's finished pulse, then moves to the next live enemy. It drives the shared turn counter, rotation and phase code that every enemy unit consumes as `state_in`, `turn_in` and `rotate_in`.

## Interface
Parameters:
- `NUM_ENEMIES`, 4: number of enemy units sequenced (1–8).
- `TIMEOUT_CYCLES`, 1_000_000: watchdog limit per enemy move, in clock cycles.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `start_in`  in  1  pulse; begins a game from IDLE.
- `player_done_in`  in  1  pulse; player has committed its move.
- `new_frame_in`  in  1  pulse; one cycle at start of vertical blanking.
- `enemy_alive_in`  in  NUM_ENEMIES  live mask; dead enemies are skipped.
- `enemy_busy_in`  in  NUM_ENEMIES  per-enemy `busy_out`.
- `enemy_finished_in`  in  NUM_ENEMIES  per-enemy `finished_out` pulse.
- `state_out`  out  4  phase code: 0 IDLE, 1 PLAYER, 2 E_START, 3 E_WAIT, 4 ADVANCE.
- `turn_out`  out  4  turn counter.
- `rotate_out`  out  2  global rotation.
- `enemy_start_out`  out  NUM_ENEMIES  one-hot, single-cycle start pulse.
- `active_idx_out`  out  3  index of the enemy currently sequenced.
- `player_turn_out`  out  1  high while in PLAYER.
- `round_done_out`  out  1  one-cycle pulse in ADVANCE.
- `timeout_out`  out  1  one-cycle pulse on watchdog expiry.

## Operation
- All outputs are registered. Reset forces IDLE, and every output is 0.
- **IDLE**
  - `start_in` → PLAYER.
  - `turn_out` and `rotate_out` are cleared to 0.
- **PLAYER**
  - `player_turn_out`=1.
  - `player_done_in` → search for the lowest alive index ≥0.
  - Found → E_START with `active_idx_out` set to that index.
  - None alive → ADVANCE.
- **E_START** (the checks below are evaluated in this priority order)
  - If `enemy_alive_in[idx]`=0: search for the next alive index >idx. Found → stay in E_START with the new index. None → ADVANCE. No start pulse is issued.
  - Else if `new_frame_in`=1 and `enemy_busy_in[idx]`=0: assert `enemy_start_out[idx]` for exactly one cycle, go to E_WAIT, and clear the watchdog.
  - Otherwise hold.
- **E_WAIT**
  - The watchdog increments every cycle.
  - `enemy_finished_in[idx]` → search for the next alive index >idx. Found → E_START. None → ADVANCE.
  - Finished pulses on other indices are ignored.
  - Watchdog reaches `TIMEOUT_CYCLES`-1 with no finish → pulse `timeout_out`, then behave exactly as if finished.
- **ADVANCE** (one cycle)
  - `turn_out` +1, wrapping 15→0.
  - `rotate_out` +1 mod 4.
  - `round_done_out`=1.
  - Next state is PLAYER.
- **Next-alive search**
  - Combinational find-first over `enemy_alive_in` masked to indices >idx.
  - The mask is sampled in the deciding cycle.
- **Ignored inputs**
  - `start_in` outside IDLE is ignored.
  - `player_done_in` outside PLAYER is ignored.
  - There is no return to IDLE except via `rst`.
- **Reset mid-operation**
  - The FSM returns immediately to IDLE and all outputs go to 0.
  - Any in-flight start pulse is dropped.

## Timing
- **Decision latency:** a decision input sampled at cycle k changes `state_out` and the other outputs at cycle k+1.
- **Player to first start:**
  - `player_done_in` at k gives `state_out`=2 at k+1.
  - The earliest `enemy_start_out` is at k+2, provided `new_frame_in` is high at k+1.
- **Start pulse:** `enemy_start_out` is high for exactly the cycle in which `state_out` first reads 3.
- **Finish to next start:** at minimum 2 cycles, since an E_START cycle must see `new_frame_in`.
- **Finish and timeout in the same cycle:** finish wins and `timeout_out` stays 0.
- **Watchdog width:** `$clog2(TIMEOUT_CYCLES)` bits; it saturates and does not wrap.
- **`state_out` range:** always in 0–4. Unused codes are never driven.

## Test plan
- **Reset:** assert `rst` mid-E_WAIT → next cycle `state_out`=0, `turn_out`=0, `rotate_out`=0, all pulses 0.
- **Full round, 4 enemies:**
  - Stimulus: all alive, `new_frame_in` every 10 cycles, each enemy finishes 5 cycles after its start.
  - Required: starts appear one-hot in order 0001, 0010, 0100, 1000, each on a frame boundary.
  - After enemy 3 finishes: `round_done_out` pulses once, `turn_out`=1, `rotate_out`=1, `state_out`=1.
- **Skip dead enemies:**
  - Stimulus: alive mask 1010.
  - Required: only indices 1 and 3 are started.
  - With mask 0000: `player_done_in` → ADVANCE next cycle with no starts.
- **Busy gating:**
  - Stimulus: `enemy_busy_in[0]`=1 across two frame pulses, then released.
  - Required: the start is issued only on the first frame pulse after release.
- **Watchdog:**
  - Stimulus: `TIMEOUT_CYCLES`=16, enemy 0 never finishes.
  - Required: `timeout_out` pulses 16 cycles after the start, and the sequencer proceeds to enemy 1.
  - Finish and timeout in the same cycle → no `timeout_out` pulse.
- **Wrap and ignored inputs:**
  - Stimulus: 16 rounds completed; `player_done_in` and `start_in` pulsed during E_WAIT.
  - Required: `turn_out` wraps to 0 and `rotate_out` reads 0.
  - Required: the stray pulses cause no state change.

Source files
------------

// File: rtl/turn_sequencer.sv
// -----------------------------------------------------------------------------
// turn_sequencer
//
// Turn controller for the enemy sprite units. A game alternates one PLAYER
// phase with a round of enemy phases. In each round every live enemy is
// started once, in ascending index order. A start is only issued on a frame
// boundary while that enemy is idle. The sequencer then waits for that
// enemy's finished pulse, or for the watchdog to expire. Each completed round
// bumps the shared turn counter and the global rotation.
//
// Ports
//   clk                system clock (single domain)
//   rst                synchronous, active-high reset
//   start_in           pulse, leaves IDLE and begins the game
//   player_done_in     pulse, player committed its move (PLAYER only)
//   new_frame_in       pulse, start of vertical blanking
//   enemy_alive_in     live mask; dead enemies are skipped
//   enemy_busy_in      per-enemy busy flag; blocks a start
//   enemy_finished_in  per-enemy finished pulse
//   state_out          phase code 0 IDLE, 1 PLAYER, 2 E_START, 3 E_WAIT, 4 ADVANCE
//   turn_out           turn counter, wraps 15 -> 0
//   rotate_out         global rotation, mod 4
//   enemy_start_out    one-hot, single-cycle start pulse
//   active_idx_out     index of the enemy currently sequenced
//   player_turn_out    high while in PLAYER
//   round_done_out     one-cycle pulse while in ADVANCE
//   timeout_out        one-cycle pulse on watchdog expiry
// -----------------------------------------------------------------------------
module turn_sequencer #(
   parameter int NUM_ENEMIES    = 4,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_in,
   input  logic                   player_done_in,
   input  logic                   new_frame_in,
   input  logic [NUM_ENEMIES-1:0] enemy_alive_in,
   input  logic [NUM_ENEMIES-1:0] enemy_busy_in,
   input  logic [NUM_ENEMIES-1:0] enemy_finished_in,
   output logic [3:0]             state_out,
   output logic [3:0]             turn_out,
   output logic [1:0]             rotate_out,
   output logic [NUM_ENEMIES-1:0] enemy_start_out,
   output logic [2:0]             active_idx_out,
   output logic                   player_turn_out,
   output logic                   round_done_out,
   output logic                   timeout_out
);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_PLAYER  = 4'd1,
      S_E_START = 4'd2,
      S_E_WAIT  = 4'd3,
      S_ADVANCE = 4'd4
   } state_t;

   // Watchdog is just wide enough to hold TIMEOUT_CYCLES-1 and saturates there.
   localparam int              WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   // Registered state and outputs
   state_t                 state_q;
   logic [2:0]             idx_q;
   logic [WD_W-1:0]        wdog_q;
   logic [3:0]             turn_q;
   logic [1:0]             rotate_q;
   logic [NUM_ENEMIES-1:0] start_q;
   logic                   player_turn_q;
   logic                   round_done_q;
   logic                   timeout_q;

   // Next values
   state_t                 state_d;
   logic [2:0]             idx_d;
   logic [WD_W-1:0]        wdog_d;
   logic [3:0]             turn_d;
   logic [1:0]             rotate_d;
   logic [NUM_ENEMIES-1:0] start_d;
   logic                   player_turn_d;
   logic                   round_done_d;
   logic                   timeout_d;

   // Decision strobes from the next-state logic
   logic                   fire;
   logic                   wd_expired;

   // Per-index view of the currently sequenced enemy
   logic                   cur_alive;
   logic                   cur_busy;
   logic                   cur_finished;
   logic [NUM_ENEMIES-1:0] cur_onehot;

   // Find-first results
   logic                   first_found;
   logic [2:0]             first_idx;
   logic                   next_found;
   logic [2:0]             next_idx;

   // NOTE: every signal written in an always_comb gets a default first, so no
   // path through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      cur_alive    = 1'b0;
      cur_busy     = 1'b0;
      cur_finished = 1'b0;
      cur_onehot   = '0;
      for (int i = 0; i < NUM_ENEMIES; i++) begin
         if (idx_q == 3'(i)) begin
            cur_onehot[i] = 1'b1;
            cur_alive     = enemy_alive_in[i];
            cur_busy      = enemy_busy_in[i];
            cur_finished  = enemy_finished_in[i];
         end
      end
   end

   // Lowest alive index overall, and lowest alive index strictly above idx_q.
   // Scanning downwards lets the last hit (the lowest index) win.
   always_comb begin
      first_found = 1'b0;
      first_idx   = '0;
      next_found  = 1'b0;
      next_idx    = '0;
      for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
         if (enemy_alive_in[i]) begin
            first_found = 1'b1;
            first_idx   = 3'(i);
            if (3'(i) > idx_q) begin
               next_found = 1'b1;
               next_idx   = 3'(i);
            end
         end
      end
   end

   // State register
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         idx_q         <= '0;
         wdog_q        <= '0;
         turn_q        <= '0;
         rotate_q      <= '0;
         start_q       <= '0;
         player_turn_q <= 1'b0;
         round_done_q  <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         wdog_q        <= wdog_d;
         turn_q        <= turn_d;
         rotate_q      <= rotate_d;
         start_q       <= start_d;
         player_turn_q <= player_turn_d;
         round_done_q  <= round_done_d;
         timeout_q     <= timeout_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      fire       = 1'b0;
      wd_expired = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_in) state_d = S_PLAYER;
         end
         S_PLAYER: begin
            if (player_done_in) begin
               if (first_found) begin
                  state_d = S_E_START;
                  idx_d   = first_idx;
               end else begin
                  state_d = S_ADVANCE;
               end
            end
         end
         S_E_START: begin
            // An enemy that died while waiting for its frame is skipped
            // before any start is considered.
            if (!cur_alive) begin
               if (next_found) idx_d   = next_idx;
               else            state_d = S_ADVANCE;
            end else if (new_frame_in && !cur_busy) begin
               fire    = 1'b1;
               state_d = S_E_WAIT;
            end
         end
         S_E_WAIT: begin
            // A finish in the expiry cycle wins over the timeout.
            wd_expired = !cur_finished && (wdog_q == WD_LAST);
            if (cur_finished || wd_expired) begin
               if (next_found) begin
                  state_d = S_E_START;
                  idx_d   = next_idx;
               end else begin
                  state_d = S_ADVANCE;
               end
            end
         end
         S_ADVANCE: begin
            state_d = S_PLAYER;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output logic: next values for the registered outputs and the watchdog
   always_comb begin
      turn_d        = turn_q;
      rotate_d      = rotate_q;
      wdog_d        = wdog_q;
      start_d       = fire ? cur_onehot : '0;
      player_turn_d = (state_d == S_PLAYER);
      // ADVANCE lasts one cycle, so this is high only on entry.
      round_done_d  = (state_d == S_ADVANCE);
      timeout_d     = wd_expired;

      if (state_q == S_IDLE) begin
         turn_d   = '0;
         rotate_d = '0;
      end

      // Counters step on entry so the new values are visible during ADVANCE.
      if (state_d == S_ADVANCE) begin
         turn_d   = turn_q + 4'd1;
         rotate_d = rotate_q + 2'd1;
      end

      if (fire) begin
         wdog_d = '0;
      end else if ((state_q == S_E_WAIT) && (wdog_q != WD_LAST)) begin
         wdog_d = wdog_q + 1'b1;
      end
   end

   assign state_out       = state_q;
   assign turn_out        = turn_q;
   assign rotate_out      = rotate_q;
   assign enemy_start_out = start_q;
   assign active_idx_out  = idx_q;
   assign player_turn_out = player_turn_q;
   assign round_done_out  = round_done_q;
   assign timeout_out     = timeout_q;

endmodule
